spi_cmd_decoder: RTL and testbench
==================================

SPI_CMD_DECODER -- requirements
Module: spi_cmd_decoder

Interface
REQ-001 SHALL have parameter: DEVICE_ID, 8'hA5, constant returned by register 0x0.
REQ-002 SHALL have parameter: ERR_SAT, 8'hFF, saturation value of the error counter.
REQ-003 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: cs_n  input  1  SPI frame select, active low, already synchronized to clk.
REQ-006 SHALL have port: rx_valid  input  1  one-cycle pulse: rx_byte holds a completed byte.
REQ-007 SHALL have port: rx_byte  input  8  byte received from the SPI slave.
REQ-008 SHALL have port: tx_byte  output  8  byte for the SPI slave to shift out in the next byte slot.
REQ-009 SHALL have port: disp_value  output  16  value for the seven-segment display.
REQ-010 SHALL have port: ctrl  output  8  contents of the CTRL register.
REQ-011 SHALL have port: frame_err  output  1  one-cycle pulse on a rejected command byte.

Function
REQ-012 SHALL implement the register map: 0x0 ID (RO, DEVICE_ID); 0x1 SCRATCH (RW); 0x2 DISP_LO (RW); 0x3 DISP_HI (RW); 0x4 CTRL (RW); 0x5 rsvd (reads 0x00); 0x6 FRAME_CNT (RO); 0x7 ERR_CNT (RO).
REQ-013 SHALL implement FSM states IDLE, CMD, WRITE, READ, DISCARD.
REQ-014 SHALL move IDLE->CMD on the first cycle cs_n is sampled low after having been sampled high.
REQ-015 SHALL, in CMD on rx_valid, decode the command byte: bit7=1 write, bit7=0 read, bits2:0 start address, bits6:3 required zero.
REQ-016 SHALL, on a command with nonzero bits6:3, pulse frame_err, increment ERR_CNT (saturating at ERR_SAT), and enter DISCARD.
REQ-017 SHALL, in WRITE, write each rx_valid byte to the current address on the following clock edge, then increment the address mod 8 (0x7 wraps to 0x0).
REQ-018 SHALL silently ignore writes to RO/reserved addresses, still incrementing the address.
REQ-019 SHALL, in READ, drive tx_byte = reg[addr] one cycle after the command rx_valid and advance to reg[addr+1 mod 8] one cycle after each further rx_valid.
REQ-020 SHALL hold tx_byte at 8'h00 in IDLE, CMD, WRITE and DISCARD.
REQ-021 SHALL return to IDLE on any cycle cs_n is sampled high, from any state.
REQ-022 SHALL, when rx_valid and cs_n-high coincide, process the byte in the current state first, then enter IDLE.
REQ-023 SHALL stage DISP_LO/DISP_HI writes in shadow registers and copy both to disp_value in the same cycle as frame end, so the display never shows a half-updated value.
REQ-024 SHALL increment FRAME_CNT (wrapping 0xFF->0x00) at frame end only if the frame contained at least one rx_valid.
REQ-025 SHALL ignore rx_valid while in IDLE.

Reset
REQ-026 SHALL, on rst, clear SCRATCH, DISP_LO/HI, shadows, CTRL, FRAME_CNT and ERR_CNT to 0, set state IDLE, and clear tx_byte, disp_value, ctrl and frame_err to 0.
REQ-027 SHALL, when reset is released with cs_n low, stay in IDLE until cs_n is sampled high, so a partial frame is ignored.

Structure
REQ-028 SHALL take the state enum, the register address constants and the command bit positions from shared package spi_cmd_pkg.
REQ-029 SHALL place the register array, RO masking and shadow/commit logic in one sub-module, spi_reg_file; the FSM stays in spi_cmd_decoder.

Verification
REQ-030 SHALL test a write: frame {0x82, 0x34, 0x12} -> disp_value stays 0x0000 until cs_n rises, then becomes 0x1234; FRAME_CNT = 1.
REQ-031 SHALL test a read with wrap: frame {0x06, xx, xx, xx} after two prior frames -> tx_byte sequence 0x02 (FRAME_CNT), 0x00 (ERR_CNT), 0xA5 (ID, wrapped), 0x00 (SCRATCH).
REQ-032 SHALL test a bad command: frame {0x48, 0x55} -> frame_err pulses once, ERR_CNT = 1, SCRATCH unchanged; 256 further bad frames -> ERR_CNT holds at 0xFF.
REQ-033 SHALL test an RO write: frame {0x80, 0x00, 0x77} -> ID still reads 0xA5, SCRATCH = 0x77.
REQ-034 SHALL test coincident events: rx_valid with data 0x99 on the same cycle cs_n rises during a write to 0x4 -> ctrl = 0x99, state IDLE next cycle.
REQ-035 SHALL test reset mid-frame: rst asserted after byte 0x81 with cs_n held low, then released -> further bytes ignored until cs_n toggles high then low; all registers read 0.

Source files
------------

// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command decoder: FSM states, register map
// addresses and the layout of the command byte.
package spi_cmd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WRITE,
        ST_READ,
        ST_DISCARD
    } state_t;

    localparam logic [2:0] ADDR_ID        = 3'h0;
    localparam logic [2:0] ADDR_SCRATCH   = 3'h1;
    localparam logic [2:0] ADDR_DISP_LO   = 3'h2;
    localparam logic [2:0] ADDR_DISP_HI   = 3'h3;
    localparam logic [2:0] ADDR_CTRL      = 3'h4;
    localparam logic [2:0] ADDR_RSVD      = 3'h5;
    localparam logic [2:0] ADDR_FRAME_CNT = 3'h6;
    localparam logic [2:0] ADDR_ERR_CNT   = 3'h7;

    // Command byte: [7] write/not-read, [6:3] must be zero, [2:0] start address.
    localparam int CMD_RW_BIT   = 7;
    localparam int CMD_MBZ_MSB  = 6;
    localparam int CMD_MBZ_LSB  = 3;
    localparam int CMD_ADDR_MSB = 2;
    localparam int CMD_ADDR_LSB = 0;

    function automatic logic cmd_is_bad(input logic [7:0] cmd);
        return |cmd[CMD_MBZ_MSB:CMD_MBZ_LSB];
    endfunction

    function automatic logic cmd_is_write(input logic [7:0] cmd);
        return cmd[CMD_RW_BIT];
    endfunction

    function automatic logic [2:0] cmd_addr(input logic [7:0] cmd);
        return cmd[CMD_ADDR_MSB:CMD_ADDR_LSB];
    endfunction

endpackage

// File: rtl/spi_reg_file.sv
// Register map behind the SPI command decoder: RW registers, read-only
// counters, and the display shadow pair committed atomically at frame end.
module spi_reg_file #(
    parameter logic [7:0] DEVICE_ID = 8'hA5,
    parameter logic [7:0] ERR_SAT   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [7:0]  wr_data,
    input  logic [2:0]  rd_addr,
    output logic [7:0]  rd_data,
    input  logic        err_inc,
    input  logic        frame_end,
    input  logic        frame_inc,
    output logic [15:0] disp_value,
    output logic [7:0]  ctrl
);
    import spi_cmd_pkg::*;

    logic [7:0] scratch;
    logic [7:0] disp_lo_sh;
    logic [7:0] disp_hi_sh;
    logic [7:0] ctrl_q;
    logic [7:0] frame_cnt;
    logic [7:0] err_cnt;
    logic [7:0] disp_lo_next;
    logic [7:0] disp_hi_next;

    // A display byte written on the very edge the frame closes must still
    // make it into the committed value, so commit from the next-state shadows.
    assign disp_lo_next = (wr_en && (wr_addr == ADDR_DISP_LO)) ? wr_data : disp_lo_sh;
    assign disp_hi_next = (wr_en && (wr_addr == ADDR_DISP_HI)) ? wr_data : disp_hi_sh;

    assign ctrl = ctrl_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            scratch    <= 8'h00;
            disp_lo_sh <= 8'h00;
            disp_hi_sh <= 8'h00;
            ctrl_q     <= 8'h00;
            frame_cnt  <= 8'h00;
            err_cnt    <= 8'h00;
            disp_value <= 16'h0000;
        end else begin
            disp_lo_sh <= disp_lo_next;
            disp_hi_sh <= disp_hi_next;
            if (wr_en && (wr_addr == ADDR_SCRATCH)) begin
                scratch <= wr_data;
            end
            if (wr_en && (wr_addr == ADDR_CTRL)) begin
                ctrl_q <= wr_data;
            end
            if (err_inc && (err_cnt != ERR_SAT)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (frame_inc) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
            if (frame_end) begin
                disp_value <= {disp_hi_next, disp_lo_next};
            end
        end
    end

    // Display registers read back the staged value, i.e. the last byte written.
    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            ADDR_ID:        rd_data = DEVICE_ID;
            ADDR_SCRATCH:   rd_data = scratch;
            ADDR_DISP_LO:   rd_data = disp_lo_sh;
            ADDR_DISP_HI:   rd_data = disp_hi_sh;
            ADDR_CTRL:      rd_data = ctrl_q;
            ADDR_RSVD:      rd_data = 8'h00;
            ADDR_FRAME_CNT: rd_data = frame_cnt;
            ADDR_ERR_CNT:   rd_data = err_cnt;
            default:        rd_data = 8'h00;
        endcase
    end

endmodule

// File: rtl/spi_cmd_decoder.sv
// SPI command decoder: frames a byte stream into a command byte followed by
// register writes or reads, and drives the reply byte for the SPI slave.
module spi_cmd_decoder #(
    parameter logic [7:0] DEVICE_ID = 8'hA5,
    parameter logic [7:0] ERR_SAT   = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs_n,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic [7:0]  tx_byte,
    output logic [15:0] disp_value,
    output logic [7:0]  ctrl,
    output logic        frame_err
);
    import spi_cmd_pkg::*;

    state_t     state;
    state_t     state_d;
    logic [2:0] addr;
    logic [2:0] addr_d;
    logic [7:0] tx_d;
    logic       cs_prev;
    logic       frame_has_byte;
    logic       err_pulse;
    logic       wr_en;
    logic [2:0] rd_addr;
    logic [7:0] rd_data;
    logic       byte_seen;
    logic       frame_end;
    logic       frame_inc;

    assign byte_seen = rx_valid && (state != ST_IDLE);
    assign frame_end = cs_n && (state != ST_IDLE);
    assign frame_inc = frame_end && (frame_has_byte || byte_seen);

    // The command byte addresses the first read directly; later bytes read ahead.
    assign rd_addr = (state == ST_CMD) ? cmd_addr(rx_byte) : addr + 3'd1;

    spi_reg_file #(
        .DEVICE_ID (DEVICE_ID),
        .ERR_SAT   (ERR_SAT)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (addr),
        .wr_data    (rx_byte),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .err_inc    (err_pulse),
        .frame_end  (frame_end),
        .frame_inc  (frame_inc),
        .disp_value (disp_value),
        .ctrl       (ctrl)
    );

    // cs_prev starts low so a frame already in progress at reset release is skipped.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            addr           <= 3'd0;
            tx_byte        <= 8'h00;
            frame_err      <= 1'b0;
            cs_prev        <= 1'b0;
            frame_has_byte <= 1'b0;
        end else begin
            state          <= state_d;
            addr           <= addr_d;
            tx_byte        <= tx_d;
            frame_err      <= err_pulse;
            cs_prev        <= cs_n;
            frame_has_byte <= frame_end ? 1'b0 : (frame_has_byte | byte_seen);
        end
    end

    always_comb begin
        state_d   = state;
        addr_d    = addr;
        tx_d      = 8'h00;
        err_pulse = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!cs_n && cs_prev) begin
                    state_d = ST_CMD;
                end
            end
            ST_CMD: begin
                if (rx_valid) begin
                    if (cmd_is_bad(rx_byte)) begin
                        err_pulse = 1'b1;
                        state_d   = ST_DISCARD;
                    end else if (cmd_is_write(rx_byte)) begin
                        addr_d  = cmd_addr(rx_byte);
                        state_d = ST_WRITE;
                    end else begin
                        addr_d  = cmd_addr(rx_byte);
                        tx_d    = rd_data;
                        state_d = ST_READ;
                    end
                end
            end
            ST_WRITE: begin
                if (rx_valid) begin
                    wr_en  = 1'b1;
                    addr_d = addr + 3'd1;
                end
            end
            ST_READ: begin
                tx_d = tx_byte;
                if (rx_valid) begin
                    addr_d = addr + 3'd1;
                    tx_d   = rd_data;
                end
            end
            ST_DISCARD: begin
                state_d = ST_DISCARD;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Frame end wins over everything except the byte already handled above.
        if (cs_n) begin
            state_d = ST_IDLE;
            tx_d    = 8'h00;
        end
    end

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Self-checking bench for spi_cmd_decoder: directed frames with literal
// expectations, then randomized frames checked every cycle against a model.
module tb_spi_cmd_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs_n;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic [7:0]  tx_byte;
    logic [15:0] disp_value;
    logic [7:0]  ctrl;
    logic        frame_err;

    always #5 clk = ~clk;

    spi_cmd_decoder #(
        .DEVICE_ID (8'hA5),
        .ERR_SAT   (8'hFF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cs_n       (cs_n),
        .rx_valid   (rx_valid),
        .rx_byte    (rx_byte),
        .tx_byte    (tx_byte),
        .disp_value (disp_value),
        .ctrl       (ctrl),
        .frame_err  (frame_err)
    );

    typedef enum {M_IDLE, M_CMD, M_WR, M_RD, M_DISC} mode_t;

    int vectors     = 0;
    int miscompares = 0;
    int err_pulses  = 0;
    bit chk_on      = 1'b0;

    // Frame-level reference model of the register map and the reply stream.
    mode_t       m_mode;
    logic [2:0]  m_addr;
    logic        m_prev_high;
    logic        m_has_byte;
    logic [7:0]  m_scratch, m_lo, m_hi, m_ctrl, m_fcnt, m_ecnt;
    logic [15:0] m_disp;
    logic [7:0]  exp_tx;
    logic        exp_err;

    logic [7:0]  frame_buf [16];
    logic [7:0]  tx_log    [16];

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            checkOutput("tx_byte", 16'(tx_byte), 16'(exp_tx));
            checkOutput("disp_value", disp_value, m_disp);
            checkOutput("ctrl", 16'(ctrl), 16'(m_ctrl));
            checkOutput("frame_err", 16'(frame_err), 16'(exp_err));
            if (frame_err === 1'b1) err_pulses++;
        end
    end

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return 8'hA5;
            3'd1: return m_scratch;
            3'd2: return m_lo;
            3'd3: return m_hi;
            3'd4: return m_ctrl;
            3'd6: return m_fcnt;
            3'd7: return m_ecnt;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_addr = 3'd0; m_prev_high = 1'b0; m_has_byte = 1'b0;
        m_scratch = 8'h00; m_lo = 8'h00; m_hi = 8'h00; m_ctrl = 8'h00;
        m_fcnt = 8'h00; m_ecnt = 8'h00; m_disp = 16'h0000;
        exp_tx = 8'h00; exp_err = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_mode == M_IDLE) return;
        m_has_byte = 1'b1;
        case (m_mode)
            M_CMD: begin
                if (b[6:3] != 4'd0) begin
                    if (m_ecnt != 8'hFF) m_ecnt = m_ecnt + 8'd1;
                    exp_err = 1'b1;
                    m_mode  = M_DISC;
                end else begin
                    m_addr = b[2:0];
                    if (b[7]) m_mode = M_WR;
                    else begin
                        m_mode = M_RD;
                        exp_tx = model_read(m_addr);
                    end
                end
            end
            M_WR: begin
                case (m_addr)
                    3'd1: m_scratch = b;
                    3'd2: m_lo = b;
                    3'd3: m_hi = b;
                    3'd4: m_ctrl = b;
                    default: ;
                endcase
                m_addr = m_addr + 3'd1;
            end
            M_RD: begin
                m_addr = m_addr + 3'd1;
                exp_tx = model_read(m_addr);
            end
            default: ;
        endcase
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic applyStimulus(input logic c, input logic v, input logic [7:0] b);
        logic r;
        cs_n = c; rx_valid = v; rx_byte = b; r = rst;
        @(posedge clk);
        #1;
        exp_err = 1'b0;
        if (r) model_reset();
        else begin
            if (v) model_byte(b);
            if (c && m_mode != M_IDLE) begin
                m_disp = {m_hi, m_lo};
                if (m_has_byte) m_fcnt = m_fcnt + 8'd1;
                m_has_byte = 1'b0;
                m_mode = M_IDLE;
                exp_tx = 8'h00;
            end else if (!c && m_mode == M_IDLE && m_prev_high) begin
                m_mode = M_CMD;
            end
            m_prev_high = c;
        end
    endtask

    task automatic run_frame(input int n, input bit coinc, input int maxgap);
        applyStimulus(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < n; i++) begin
            bit last_c;
            last_c = (i == n - 1) && coinc;
            applyStimulus(last_c, 1'b1, frame_buf[i]);
            tx_log[i] = tx_byte;
            if (!last_c) begin
                int g;
                g = $urandom_range(0, maxgap);
                for (int k = 0; k < g; k++) applyStimulus(1'b0, 1'b0, 8'($urandom));
            end
        end
        if (!coinc || n == 0) applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
    endtask

    initial begin
        int p0;
        rst = 1'b1; cs_n = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00;
        model_reset();
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        chk_on = 1'b1;
        rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("reset_tx", 16'(tx_byte), 16'h0000);
        checkOutput("reset_disp", disp_value, 16'h0000);
        checkOutput("reset_ctrl", 16'(ctrl), 16'h0000);
        checkOutput("reset_err", 16'(frame_err), 16'h0000);

        // Display write: committed only when the frame closes.
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h82);
        applyStimulus(1'b0, 1'b1, 8'h34);
        applyStimulus(1'b0, 1'b1, 8'h12);
        checkOutput("disp_before_end", disp_value, 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00);
        checkOutput("disp_after_end", disp_value, 16'h1234);
        applyStimulus(1'b1, 1'b0, 8'h00);

        frame_buf[0] = 8'h84; frame_buf[1] = 8'h5A;
        run_frame(2, 1'b0, 1);
        checkOutput("ctrl_5a", 16'(ctrl), 16'h005A);

        // Read from FRAME_CNT wrapping through ERR_CNT, ID and SCRATCH.
        frame_buf[0] = 8'h06; frame_buf[1] = 8'h00; frame_buf[2] = 8'h00; frame_buf[3] = 8'h00;
        run_frame(4, 1'b0, 2);
        checkOutput("rd_frame_cnt", 16'(tx_log[0]), 16'h0002);
        checkOutput("rd_err_cnt", 16'(tx_log[1]), 16'h0000);
        checkOutput("rd_id_wrap", 16'(tx_log[2]), 16'h00A5);
        checkOutput("rd_scratch", 16'(tx_log[3]), 16'h0000);

        // Bad command.
        p0 = err_pulses;
        frame_buf[0] = 8'h48; frame_buf[1] = 8'h55;
        run_frame(2, 1'b0, 1);
        checkOutput("bad_cmd_pulses", 16'(err_pulses - p0), 16'h0001);
        frame_buf[0] = 8'h07; frame_buf[1] = 8'h00;
        run_frame(2, 1'b0, 0);
        checkOutput("err_cnt_1", 16'(tx_log[0]), 16'h0001);
        frame_buf[0] = 8'h01;
        run_frame(1, 1'b0, 0);
        checkOutput("scratch_kept", 16'(tx_log[0]), 16'h0000);
        frame_buf[0] = 8'h48;
        for (int i = 0; i < 256; i++) run_frame(1, 1'b0, 0);
        frame_buf[0] = 8'h07;
        run_frame(1, 1'b0, 0);
        checkOutput("err_cnt_sat", 16'(tx_log[0]), 16'h00FF);

        // Write across the read-only ID register.
        frame_buf[0] = 8'h80; frame_buf[1] = 8'h00; frame_buf[2] = 8'h77;
        run_frame(3, 1'b0, 1);
        frame_buf[0] = 8'h00; frame_buf[1] = 8'h00;
        run_frame(2, 1'b0, 0);
        checkOutput("id_ro", 16'(tx_log[0]), 16'h00A5);
        checkOutput("scratch_77", 16'(tx_log[1]), 16'h0077);

        // Last data byte coincides with cs_n rising.
        frame_buf[0] = 8'h84; frame_buf[1] = 8'h99;
        run_frame(2, 1'b1, 0);
        checkOutput("coinc_ctrl", 16'(ctrl), 16'h0099);
        applyStimulus(1'b1, 1'b1, 8'h11);
        checkOutput("idle_ignore_ctrl", 16'(ctrl), 16'h0099);
        checkOutput("idle_tx", 16'(tx_byte), 16'h0000);

        // Reset in the middle of a write frame with cs_n held low.
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h81);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b1, 8'h22);
        applyStimulus(1'b0, 1'b1, 8'h84);
        applyStimulus(1'b0, 1'b1, 8'h33);
        checkOutput("rst_mid_ctrl", 16'(ctrl), 16'h0000);
        applyStimulus(1'b1, 1'b0, 8'h00);
        frame_buf[0] = 8'h00;
        for (int i = 1; i < 8; i++) frame_buf[i] = 8'h00;
        run_frame(8, 1'b0, 0);
        checkOutput("post_rst_id", 16'(tx_log[0]), 16'h00A5);
        for (int i = 1; i < 8; i++) checkOutput("post_rst_reg", 16'(tx_log[i]), 16'h0000);

        // Randomized frames; the per-cycle compare does the checking.
        for (int f = 0; f < 200; f++) begin
            int n;
            logic [7:0] cmd;
            n = $urandom_range(0, 6);
            cmd = 8'($urandom);
            if ($urandom_range(0, 9) != 0) cmd[6:3] = 4'd0;
            frame_buf[0] = cmd;
            for (int i = 1; i < 16; i++) frame_buf[i] = 8'($urandom);
            run_frame(n, ($urandom_range(0, 3) == 0), 2);
            if ($urandom_range(0, 4) == 0) applyStimulus(1'b1, 1'b1, 8'($urandom));
        end

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
